// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Shared types for the CPU memory subsystem.
//   word_t     : 32-bit machine word used for addresses and data.
//   ramstate_t : status reported by the shared RAM each cycle.
//   arbstate_t : mem_arbiter state encoding, exported so benches can probe it.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DACC = 3'd1,
    IACC = 3'd2,
    DHIT = 3'd3,
    IHIT = 3'd4
  } arbstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates the instruction-fetch and data ports of the pipeline onto one
// shared RAM. Holds at most one outstanding request, retries on RAM ERROR up
// to RETRY_MAX times, and answers with a one-cycle ihit/dhit pulse. Data
// requests win over fetches, decided only while idle.
//
// Ports:
//   CLK, nRST              clock (rising edge), async active-low reset
//   iREN, iaddr            fetch request / word address
//   iload, ihit            fetched word (valid with ihit), completion pulse
//   dREN, dWEN             data read / write request (write wins)
//   daddr, dstore          data address / write data
//   dload, dhit            read data (valid with dhit), completion pulse
//   ramREN, ramWEN         RAM strobes (0 unless an access is in flight)
//   ramaddr, ramstore      RAM address / write data
//   ramload, ramstate      RAM read data / RAM status (FREE/BUSY/ACCESS/ERROR)
//   err                    sticky: a request ran out of retries
//
// Every output is decoded from registers only, so there is no combinational
// path from any input to any output.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int RETRY_MAX = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam int CW = $clog2(RETRY_MAX + 1);
  localparam logic [CW-1:0] MAXCNT = CW'(RETRY_MAX);
  localparam logic [CW-1:0] LASTTRY = CW'(RETRY_MAX - 1);

  arbstate_t   state, nxtstate;
  ramstate_t   rs;

  word_t       reqaddr, reqdata;
  logic        reqwen;
  word_t       iloadreg, dloadreg;
  logic [CW-1:0] retrycnt;
  logic        errreg;

  logic        latchd, latchi, capi, capd;
  logic        retryinc, retryclr, giveup;
  logic        dabort, iabort;

  assign rs = ramstate_t'(ramstate);

  // A write the RAM has already accepted is allowed to complete even if the
  // requester drops dWEN in that same cycle.
  assign dabort = !(dREN | dWEN) && !(reqwen && rs == ACCESS);
  // A fetch is abandoned when it is withdrawn or redirected (branch/jump flush).
  assign iabort = !iREN || (iaddr != reqaddr);

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= nxtstate;
    end
  end

  // Next-state logic. Aborts are checked before the RAM response so a
  // withdrawn request never produces a hit or bumps the retry count.
  always_comb begin
    nxtstate = state;
    latchd   = 1'b0;
    latchi   = 1'b0;
    capi     = 1'b0;
    capd     = 1'b0;
    retryinc = 1'b0;
    retryclr = 1'b0;
    giveup   = 1'b0;
    case (state)
      IDLE: begin
        if (dREN | dWEN) begin
          nxtstate = DACC;
          latchd   = 1'b1;
        end else if (iREN) begin
          nxtstate = IACC;
          latchi   = 1'b1;
        end
      end
      DACC: begin
        if (dabort) begin
          nxtstate = IDLE;
        end else begin
          case (rs)
            ACCESS: begin
              nxtstate = DHIT;
              capd     = !reqwen;
              retryclr = 1'b1;
            end
            ERROR: begin
              retryinc = 1'b1;
              if (retrycnt == LASTTRY) begin
                nxtstate = IDLE;
                giveup   = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      IACC: begin
        if (iabort) begin
          nxtstate = IDLE;
        end else begin
          case (rs)
            ACCESS: begin
              nxtstate = IHIT;
              capi     = 1'b1;
              retryclr = 1'b1;
            end
            ERROR: begin
              retryinc = 1'b1;
              if (retrycnt == LASTTRY) begin
                nxtstate = IDLE;
                giveup   = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      DHIT:    nxtstate = IDLE;
      IHIT:    nxtstate = IDLE;
      default: nxtstate = IDLE;
    endcase
  end

  // Latched request: captured once on acceptance so later input changes
  // cannot disturb the access in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      reqaddr <= '0;
      reqdata <= '0;
      reqwen  <= 1'b0;
    end else if (latchd) begin
      reqaddr <= daddr;
      reqdata <= dstore;
      reqwen  <= dWEN;
    end else if (latchi) begin
      reqaddr <= iaddr;
      reqdata <= '0;
      reqwen  <= 1'b0;
    end
  end

  // Load registers hold the last successful read so iload/dload stay stable
  // outside hit cycles.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      iloadreg <= '0;
      dloadreg <= '0;
    end else begin
      if (capi) iloadreg <= ramload;
      if (capd) dloadreg <= ramload;
    end
  end

  // Retry counter, restarted for every new request and saturating at
  // RETRY_MAX; err is sticky until reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      retrycnt <= '0;
      errreg   <= 1'b0;
    end else begin
      if (latchd || latchi || retryclr) begin
        retrycnt <= '0;
      end else if (retryinc && retrycnt != MAXCNT) begin
        retrycnt <= retrycnt + 1'b1;
      end
      if (giveup) errreg <= 1'b1;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = iloadreg;
    dload    = dloadreg;
    err      = errreg;
    case (state)
      DACC: begin
        ramWEN   = reqwen;
        ramREN   = !reqwen;
        ramaddr  = reqaddr;
        ramstore = reqwen ? reqdata : '0;
      end
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = reqaddr;
      end
      DHIT:    dhit = 1'b1;
      IHIT:    ihit = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. Stimulus is expressed as whole
// transactions (kind, address, RAM response pattern, optional abort); each
// transaction expands into per-cycle expected outputs from the arbiter's
// timing rules, and one compare process checks every output on every cycle.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int RETRY_MAX = 3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  word_t       iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  word_t       iload, dload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, err;

  mem_arbiter #(.RETRY_MAX(RETRY_MAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model state: last delivered load words and the sticky error flag.
  word_t mI, mD;
  logic  mErr;

  // Expected outputs for the current cycle.
  logic  eRamREN, eRamWEN, eIhit, eDhit, eErr;
  word_t eRamaddr, eRamstore, eIload, eDload;

  // Stimulus shaping knobs.
  bit    allBusy = 1'b0;
  bit    holdFetch = 1'b0;
  word_t holdAddr = '0;

  // Cycle bookkeeping for the directed literal checks.
  int cyc = 0;
  int ihitCnt = 0, dhitCnt = 0, wenCnt = 0;
  int lastIhitCyc = 0, lastDhitCyc = 0, txnStart = 0;

  always @(posedge CLK) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Compare every output against the model each cycle, away from the edge.
  initial begin : compare
    forever begin
      @(negedge CLK);
      checkOutput("ramREN",   32'(ramREN), 32'(eRamREN));
      checkOutput("ramWEN",   32'(ramWEN), 32'(eRamWEN));
      checkOutput("ramaddr",  ramaddr,     eRamaddr);
      checkOutput("ramstore", ramstore,    eRamstore);
      checkOutput("ihit",     32'(ihit),   32'(eIhit));
      checkOutput("dhit",     32'(dhit),   32'(eDhit));
      checkOutput("iload",    iload,       eIload);
      checkOutput("dload",    dload,       eDload);
      checkOutput("err",      32'(err),    32'(eErr));
      if (ihit) begin ihitCnt++; lastIhitCyc = cyc; end
      if (dhit) begin dhitCnt++; lastDhitCyc = cyc; end
      if (ramWEN) wenCnt++;
    end
  end

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic randomizeInputs();
    iREN     = 1'($urandom_range(0, 1));
    iaddr    = $urandom;
    dREN     = 1'($urandom_range(0, 1));
    dWEN     = 1'($urandom_range(0, 1));
    daddr    = $urandom;
    dstore   = $urandom;
    ramstate = 2'($urandom_range(0, 3));
    ramload  = $urandom;
  endtask

  task automatic setIdleExp();
    eRamREN   = 1'b0;
    eRamWEN   = 1'b0;
    eRamaddr  = '0;
    eRamstore = '0;
    eIhit     = 1'b0;
    eDhit     = 1'b0;
    eIload    = mI;
    eDload    = mD;
    eErr      = mErr;
  endtask

  task automatic idleCycle();
    nextCycle();
    randomizeInputs();
    iREN = 1'b0;
    dREN = 1'b0;
    dWEN = 1'b0;
    setIdleExp();
  endtask

  // kind: 0 fetch, 1 read, 2 write. Only the request fields that matter
  // are pinned; everything else stays random.
  task automatic driveRequest(input int kind, input word_t addr, input word_t wdata, input bit first);
    case (kind)
      0: begin
        iREN  = 1'b1;
        iaddr = addr;
        if (first) begin dREN = 1'b0; dWEN = 1'b0; end
      end
      1: begin
        dREN = 1'b1;
        dWEN = 1'b0;
        if (first) daddr = addr;
      end
      default: begin
        dWEN = 1'b1;
        if (first) begin daddr = addr; dstore = wdata; end
      end
    endcase
    if (holdFetch && kind != 0) begin
      iREN  = 1'b1;
      iaddr = holdAddr;
    end
  endtask

  // One transaction: request cycle (arbiter idle), then one RAM cycle per
  // response until ACCESS, abort or retry exhaustion, then the hit cycle.
  task automatic applyStimulus(input int kind, input word_t addr, input word_t wdata,
                               input word_t rdata, input int nDelay, input int nErr,
                               input int abortAt, input bit abortDrop, input word_t abortAddr);
    int dly;
    int errs;
    int errCnt;
    ramstate_t rs;
    bit aborted;
    dly = nDelay;
    errs = nErr;
    errCnt = 0;
    nextCycle();
    randomizeInputs();
    txnStart = cyc;
    driveRequest(kind, addr, wdata, 1'b1);
    setIdleExp();
    for (int j = 1; j <= 64; j++) begin
      nextCycle();
      randomizeInputs();
      driveRequest(kind, addr, wdata, 1'b0);
      if (dly > 0 && (errs == 0 || $urandom_range(0, 1) == 1)) begin
        dly--;
        rs = (allBusy || $urandom_range(0, 1) == 1) ? BUSY : FREE;
      end else if (errs > 0) begin
        errs--;
        rs = ERROR;
      end else begin
        rs = ACCESS;
      end
      ramstate = rs;
      ramload  = (rs == ACCESS) ? rdata : $urandom;
      if (j == abortAt) begin
        if (kind == 0) begin
          if (abortDrop) iREN = 1'b0;
          else iaddr = abortAddr;
        end else begin
          dREN = 1'b0;
          dWEN = 1'b0;
        end
      end
      setIdleExp();
      eRamaddr = addr;
      if (kind == 2) begin
        eRamWEN   = 1'b1;
        eRamstore = wdata;
      end else begin
        eRamREN = 1'b1;
      end
      aborted = (j == abortAt) && !(kind == 2 && rs == ACCESS);
      if (aborted) return;
      if (rs == ERROR) begin
        errCnt++;
        if (errCnt == RETRY_MAX) begin
          mErr = 1'b1;
          return;
        end
      end else if (rs == ACCESS) begin
        break;
      end
    end
    nextCycle();
    randomizeInputs();
    if (kind == 0) mI = rdata;
    else if (kind == 1) mD = rdata;
    setIdleExp();
    if (kind == 0) eIhit = 1'b1;
    else eDhit = 1'b1;
  endtask

  int    s, w0, i0, d0;
  int    kind, nD, nE, ab;
  word_t a;

  initial begin : stimulus
    nRST = 1'b0;
    iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramstate = 2'b00; ramload = '0;
    mI = '0; mD = '0; mErr = 1'b0;
    setIdleExp();
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_ramREN", 32'(ramREN), 32'd0);
    checkOutput("reset_ihit",   32'(ihit),   32'd0);
    checkOutput("reset_err",    32'(err),    32'd0);
    checkOutput("reset_dload",  dload,       32'd0);
    #2 nRST = 1'b1;
    idleCycle();
    idleCycle();

    // Fetch with immediate ACCESS: hit two cycles after the request.
    i0 = ihitCnt;
    applyStimulus(0, 32'h40, 32'h0, 32'h8C220004, 0, 0, -1, 1'b0, 32'h0);
    s = txnStart;
    idleCycle();
    checkOutput("fetch_latency", 32'(lastIhitCyc - s), 32'd2);
    checkOutput("fetch_ihits", 32'(ihitCnt - i0), 32'd1);
    checkOutput("fetch_iload", iload, 32'h8C220004);

    // Simultaneous data and fetch: data first, fetch hit three cycles later.
    holdFetch = 1'b1;
    holdAddr  = 32'h10;
    applyStimulus(1, 32'h200, 32'h0, 32'h12345678, 0, 0, -1, 1'b0, 32'h0);
    holdFetch = 1'b0;
    applyStimulus(0, 32'h10, 32'h0, 32'h0BADF00D, 0, 0, -1, 1'b0, 32'h0);
    idleCycle();
    checkOutput("simul_gap", 32'(lastIhitCyc - lastDhitCyc), 32'd3);
    checkOutput("simul_dload", dload, 32'h12345678);
    checkOutput("simul_iload", iload, 32'h0BADF00D);

    // Write with three BUSY cycles.
    allBusy = 1'b1;
    w0 = wenCnt;
    applyStimulus(2, 32'h80, 32'hDEADBEEF, 32'hFFFF0000, 3, 0, -1, 1'b0, 32'h0);
    allBusy = 1'b0;
    s = txnStart;
    idleCycle();
    checkOutput("write_latency", 32'(lastDhitCyc - s), 32'd5);
    checkOutput("write_wencycles", 32'(wenCnt - w0), 32'd4);
    checkOutput("write_dload_held", dload, 32'h12345678);

    // Fetch redirected from 0x20 to 0x100 while the RAM is busy.
    allBusy = 1'b1;
    i0 = ihitCnt;
    applyStimulus(0, 32'h20, 32'h0, 32'h11111111, 5, 0, 3, 1'b0, 32'h100);
    allBusy = 1'b0;
    applyStimulus(0, 32'h100, 32'h0, 32'h0000ABCD, 0, 0, -1, 1'b0, 32'h0);
    idleCycle();
    checkOutput("abort_ihits", 32'(ihitCnt - i0), 32'd1);
    checkOutput("abort_iload", iload, 32'h0000ABCD);

    // Retries exhausted on a read, then a normal read.
    d0 = dhitCnt;
    applyStimulus(1, 32'h300, 32'h0, 32'h55555555, 0, RETRY_MAX, -1, 1'b0, 32'h0);
    idleCycle();
    checkOutput("error_err", 32'(err), 32'd1);
    checkOutput("error_dhits", 32'(dhitCnt - d0), 32'd0);
    checkOutput("error_state", 32'(dut.state), 32'(IDLE));
    applyStimulus(1, 32'h304, 32'h0, 32'h66666666, 1, 1, -1, 1'b0, 32'h0);
    idleCycle();
    checkOutput("after_error_dload", dload, 32'h66666666);
    checkOutput("after_error_err", 32'(err), 32'd1);

    // Reset asserted in the middle of a data access.
    nextCycle();
    randomizeInputs();
    iREN = 1'b0; dREN = 1'b1; dWEN = 1'b0; daddr = 32'h400;
    setIdleExp();
    nextCycle();
    randomizeInputs();
    iREN = 1'b0; dREN = 1'b1; dWEN = 1'b0; ramstate = BUSY;
    setIdleExp();
    eRamREN  = 1'b1;
    eRamaddr = 32'h400;
    #2;
    nRST = 1'b0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    mI = '0; mD = '0; mErr = 1'b0;
    setIdleExp();
    #1;
    checkOutput("midreset_ramREN", 32'(ramREN), 32'd0);
    checkOutput("midreset_ramWEN", 32'(ramWEN), 32'd0);
    checkOutput("midreset_dhit",   32'(dhit),   32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #3 nRST = 1'b1;
    idleCycle();
    checkOutput("post_reset_err", 32'(err), 32'd0);
    checkOutput("post_reset_state", 32'(dut.state), 32'(IDLE));

    // Randomized transactions with aborts, errors and priority noise.
    for (int t = 0; t < 400; t++) begin
      kind = $urandom_range(0, 2);
      nD   = $urandom_range(0, 4);
      nE   = $urandom_range(0, RETRY_MAX);
      a    = $urandom;
      ab   = -1;
      if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, nD + nE + 1);
      holdFetch = (kind != 0) && ($urandom_range(0, 3) == 0);
      holdAddr  = $urandom;
      applyStimulus(kind, a, $urandom, $urandom, nD, nE, ab,
                    1'($urandom_range(0, 1)), a ^ ($urandom | 32'h1));
      holdFetch = 1'b0;
      if ($urandom_range(0, 3) == 0) idleCycle();
    end
    idleCycle();
    idleCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
